// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling FIFO with first-word-fall-through output.
// It flushes on a redirect and presents a canonical NOP to decode when empty.
module if_id_queue #(
   parameter int unsigned PC_SIZE  = 32,
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_SIZE-1:0]         in_pc,
   input  logic [31:0]                in_instruction,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_SIZE-1:0]         out_pc,
   output logic [31:0]                out_instruction,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned INST_W = 32;

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   logic [PC_SIZE-1:0] pc_mem_q   [DEPTH];
   logic [PC_SIZE-1:0] pc_mem_d   [DEPTH];
   logic [INST_W-1:0]  inst_mem_q [DEPTH];
   logic [INST_W-1:0]  inst_mem_d [DEPTH];

   logic push;
   logic pop;

   // Handshake terms; in_ready looks only at registered occupancy, so a pop
   // in the same cycle as a full queue never opens a slot for a push.
   always_comb begin
      in_ready  = reset && (count_q < CNT_W'(DEPTH));
      out_valid = (count_q != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
   end

   // Head read; empty queue presents a zero PC and the NOP word.
   always_comb begin
      out_pc          = '0;
      out_instruction = NOP_INST;
      if (out_valid) begin
         out_pc          = pc_mem_q[rd_ptr_q];
         out_instruction = inst_mem_q[rd_ptr_q];
      end
      count = count_q;
   end

   // Pointer and occupancy next-state; flush overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Storage next-state; a flushed push is dropped.
   always_comb begin
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (push && !flush) begin
         pc_mem_d[wr_ptr_q]   = in_pc;
         inst_mem_d[wr_ptr_q] = in_instruction;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; only occupancy qualifies it.
   always_ff @(posedge clock) begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: fill/stall, drain, streaming wrap, flush,
// empty reads and asynchronous reset mid-stream.
module tb_if_id_queue;

   localparam int unsigned PC_SIZE = 32;
   localparam int unsigned DEPTH   = 2;
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP     = 32'h00000013;

   logic               clock;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [PC_SIZE-1:0] in_pc;
   logic [31:0]        in_instruction;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [PC_SIZE-1:0] out_pc;
   logic [31:0]        out_instruction;
   logic [CNT_W-1:0]   count;

   int checks = 0;
   int errors = 0;

   if_id_queue #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_instruction (in_instruction),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instruction(out_instruction),
      .count          (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic ov,
                            input logic ir, input logic [31:0] pc, input logic [31:0] ins);
      chk({tag, ".count"},     64'(count),           64'(cnt));
      chk({tag, ".out_valid"}, 64'(out_valid),       64'(ov));
      chk({tag, ".in_ready"},  64'(in_ready),        64'(ir));
      chk({tag, ".out_pc"},    64'(out_pc),          64'(pc));
      chk({tag, ".out_inst"},  64'(out_instruction), 64'(ins));
   endtask

   localparam logic [31:0] INS_A = 32'hA0A0_0001;
   localparam logic [31:0] INS_B = 32'hB0B0_0002;
   localparam logic [31:0] INS_C = 32'hC0C0_0003;

   initial begin
      reset          = 1'b0;
      in_valid       = 1'b0;
      in_pc          = '0;
      in_instruction = '0;
      flush          = 1'b0;
      out_ready      = 1'b0;
      #2;
      chk_state("reset", 0, 1'b0, 1'b0, 32'd0, NOP);

      // Fill to full with decode stalled; third pair must wait.
      reset = 1'b1;
      #1;
      chk("release.in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_pc = 32'd0; in_instruction = INS_A;
      tick();
      chk_state("fill1", 1, 1'b1, 1'b1, 32'd0, INS_A);
      in_pc = 32'd1; in_instruction = INS_B;
      tick();
      chk_state("fill2", 2, 1'b1, 1'b0, 32'd0, INS_A);
      in_pc = 32'd2; in_instruction = INS_C;
      tick();
      chk_state("full_hold", 2, 1'b1, 1'b0, 32'd0, INS_A);

      // Drain from full while fetch keeps offering pc 2.
      out_ready = 1'b1;
      tick();
      chk_state("drain1", 1, 1'b1, 1'b1, 32'd1, INS_B);
      tick();
      chk_state("drain2", 1, 1'b1, 1'b1, 32'd2, INS_C);
      in_valid = 1'b0;
      tick();
      chk_state("drain3", 0, 1'b0, 1'b1, 32'd0, NOP);

      // Streaming: one-deep occupancy, pointers wrap five times.
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_pc = 32'(i); in_instruction = 32'h1000 + 32'(i);
         tick();
         chk($sformatf("stream%0d.count", i), 64'(count), 64'd1);
         chk($sformatf("stream%0d.out_pc", i), 64'(out_pc), 64'(i));
         chk($sformatf("stream%0d.out_inst", i), 64'(out_instruction), 64'(32'h1000 + 32'(i)));
      end
      in_valid = 1'b0;
      tick();
      chk_state("stream_end", 0, 1'b0, 1'b1, 32'd0, NOP);

      // Flush with queue holding pc 4,5 and a pending push of pc 6.
      out_ready = 1'b0; in_valid = 1'b1;
      in_pc = 32'd4; in_instruction = 32'h4444_0004;
      tick();
      in_pc = 32'd5; in_instruction = 32'h5555_0005;
      tick();
      chk_state("pre_flush", 2, 1'b1, 1'b0, 32'd4, 32'h4444_0004);
      flush = 1'b1; in_pc = 32'd6; in_instruction = 32'h6666_0006;
      tick();
      chk_state("flush", 0, 1'b0, 1'b1, 32'd0, NOP);
      flush = 1'b0; in_pc = 32'd20; in_instruction = 32'h2020_0020;
      tick();
      chk_state("redirect", 1, 1'b1, 1'b1, 32'd20, 32'h2020_0020);

      // Held flush discards both the stored entry and every push.
      flush = 1'b1; in_pc = 32'd21; in_instruction = 32'h2121_0021;
      tick();
      chk_state("flush_hold1", 0, 1'b0, 1'b1, 32'd0, NOP);
      in_pc = 32'd22;
      tick();
      chk_state("flush_hold2", 0, 1'b0, 1'b1, 32'd0, NOP);
      flush = 1'b0; in_valid = 1'b0;

      // Empty with decode ready: nothing pops, NOP shown.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_state($sformatf("empty%0d", i), 0, 1'b0, 1'b1, 32'd0, NOP);
      end

      // Asynchronous reset mid-cycle with two entries held.
      out_ready = 1'b0; in_valid = 1'b1;
      in_pc = 32'd30; in_instruction = 32'h3030_0030;
      tick();
      in_pc = 32'd31; in_instruction = 32'h3131_0031;
      tick();
      chk("pre_reset.count", 64'(count), 64'd2);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk_state("async_reset", 0, 1'b0, 1'b0, 32'd0, NOP);
      reset = 1'b1;
      in_valid = 1'b1; in_pc = 32'd40; in_instruction = 32'h4040_0040;
      tick();
      chk_state("post_reset", 1, 1'b1, 1'b1, 32'd40, 32'h4040_0040);
      in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage and the decode stage.
- Captures each fetched {PC, instruction} pair into a small FIFO with a valid/ready handshake on both sides, so a decode stall does not drop fetched words.
- Flushes all buffered entries when a taken branch/jump redirects fetch (PCScr asserted).
- When empty, presents a canonical NOP to decode.

Parameters:
- PC_SIZE, 32, width of the program counter field.
- DEPTH, 2, number of entries; must be a power of 2 and at least 2.
- NOP_INST, 32'h00000013, instruction word driven on out_instruction when the queue is empty (addi x0,x0,0).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a valid {in_pc, in_instruction}.
- in_ready  output  1  queue can accept a push this cycle.
- in_pc  input  PC_SIZE  PC of the fetched instruction.
- in_instruction  input  32  fetched instruction word.
- flush  input  1  discard all entries (driven from PCScr).
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  PC_SIZE  PC of the head entry.
- out_instruction  output  32  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset: asynchronous on reset=0; released on reset=1.
  - While reset=0: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_pc=0, out_instruction=NOP_INST, in_ready=0.
  - Storage contents are don't-care after reset.
- in_ready = reset && (count < DEPTH).
  - Depends on registered state only; no combinational path from out_ready or flush.
  - When full, a same-cycle pop does not open a slot for a push; the push waits one cycle.
- Push: in_valid && in_ready at a rising edge writes storage[wr_ptr]. wr_ptr increments modulo DEPTH (natural wrap).
- Pop: out_valid && out_ready at a rising edge increments rd_ptr modulo DEPTH.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- out_valid = (count != 0).
  - out_pc/out_instruction = storage[rd_ptr] when out_valid=1.
  - When empty: out_pc=0 and out_instruction=NOP_INST.
  - out_pc/out_instruction are combinational reads of registered state (first-word-fall-through).
- Latency: a word pushed at edge N is visible on out_* after edge N, so decode can consume it at edge N+1. Minimum push-to-pop latency is 1 cycle.
- Flush: synchronous, highest priority.
  - At the edge where flush=1: wr_ptr=rd_ptr=0, count=0; any same-cycle push and pop are ignored.
  - After that edge, out_valid=0 and in_ready=1.
  - A push at the next edge (the redirected fetch) is accepted normally.
- Holding flush across several cycles keeps the queue empty and discards every push.
- Empty with out_ready=1: no pop, no state change; NOP is presented.
- Full with in_valid=1: no write, no pointer change; fetch must hold its pair until in_ready=1.
- Stability: out_* must not change while out_valid=1 and out_ready=0, unless flush or reset occurs.
- Reset mid-operation: all entries are lost immediately and outputs return to reset values asynchronously.

Test Plan:
1. Reset, then in_valid=1 with pc 0,1,2 and instructions A,B,C, out_ready=0 -> count goes 1 then 2. in_ready=0 after the second push. out_pc=0, out_instruction=A held. The third pair (pc 2) is not accepted.
2. From full (pc 0,1), out_ready=1 with in_valid=1 and pc=2 -> edge 1 pops pc 0 only (push blocked, count=1). Edge 2 pops pc 1 and pushes pc 2. Output sequence is 0,1,2 with no duplicates or drops.
3. Streaming with in_valid=out_ready=1 for 10 cycles, pc 0..9 -> count stays 1 after the first cycle. out_pc follows the input one cycle late. Pointers wrap at least 4 times with data intact.
4. Queue holding pc 4,5 when flush=1 with a simultaneous push of pc 6 -> next cycle count=0, out_valid=0, out_instruction=32'h00000013. Then a push of pc 20 appears on out_pc=20 one cycle later.
5. Empty queue with out_ready=1 for 3 cycles -> out_valid=0, count=0, out_pc=0, NOP presented throughout.
6. Assert reset=0 mid-stream between clock edges, with count=2 -> count=0, out_valid=0 and in_ready=0 immediately, without waiting for a clock edge. After release, the first push appears after one edge.
